pipe_stage_buf: RTL and testbench

//  Parametrised elastic pipeline-stage buffer for inter-stage payloads (F->D, D->X, X->M, M->W).

---
 rtl/npc_pipe_pkg.sv | 36 +++
 rtl/pipe_stage_mem.sv | 24 ++
 rtl/pipe_stage_buf.sv | 71 +++++++
 tb/tb_pipe_stage_buf.sv | 127 ++++++++++++
 4 files changed

// File: rtl/npc_pipe_pkg.sv
// npc_pipe_pkg: stage payload types and sizing/pointer helpers for pipe_stage_buf
package npc_pipe_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pl_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [7:0]  op;
  } decode_pl_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] result;
    logic [31:0] store_data;
    logic [3:0]  mem_op;
  } exec_pl_t;
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] wb_data;
    logic        wb_en;
  } mem_pl_t;
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
  function automatic int ptr_inc(input int ptr, input int depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/pipe_stage_mem.sv
// pipe_stage_mem: DEPTH x WIDTH storage, one sync write port, one async read port, sync clear on rst
module pipe_stage_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [PTR_W-1:0] i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic DEPTH-entry FIFO stage buffer with flush; optional PIPE_STAGE_BYPASS_EN (empty-buffer pass-through)
// Ports: clk/rst (sync, active-high), flush, s_valid/s_ready/s_data upstream,
// m_valid/m_ready/m_data downstream, count occupancy. s_ready comes from registered count only.
module pipe_stage_buf
  import npc_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = ptr_width(DEPTH);
  logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full, w_empty, w_push, w_pop, w_byp;
  logic [WIDTH-1:0] w_rd_data;
  assign w_full  = r_count == CNT_W'(DEPTH);
  assign w_empty = r_count == '0;
`ifdef PIPE_STAGE_BYPASS_EN
  // empty buffer forwards the upstream beat straight through
  assign w_byp = w_empty & s_valid & ~flush;
`else
  assign w_byp = 1'b0;
`endif
  assign s_ready = ~w_full;
  assign m_valid = w_byp | (~w_empty & ~flush);
  assign m_data  = w_byp ? s_data : w_rd_data;
  assign count   = r_count;
  assign w_pop   = ~w_empty & ~flush & m_ready;
  // a bypassed beat taken downstream the same cycle is never stored
  assign w_push  = s_valid & ~w_full & ~flush & ~(w_byp & m_ready);
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= PTR_W'(ptr_inc(int'(r_wr_ptr), DEPTH));
      if (w_pop) r_rd_ptr <= PTR_W'(ptr_inc(int'(r_rd_ptr), DEPTH));
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end
  pipe_stage_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (s_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );
`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(w_push && w_full)) else $error("pipe_stage_buf: push while full");
      assert (!(w_pop && w_empty)) else $error("pipe_stage_buf: pop while empty");
      assert (r_count <= CNT_W'(DEPTH)) else $error("pipe_stage_buf: count above DEPTH");
    end
  end
`endif
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: DEPTH=2 and DEPTH=3 buffers on shared stimulus, checked against queue models
module tb_pipe_stage_buf;
  import npc_pipe_pkg::*;
  localparam int W = $bits(fetch_pl_t) / 2;
`ifdef PIPE_STAGE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, flush, s_valid, m_ready;
  logic [W-1:0] s_data;
  logic sr2, mv2, sr3, mv3;
  logic [W-1:0] md2, md3;
  logic [1:0] cnt2, cnt3;
  int total = 0;
  int bad = 0;
  logic [W-1:0] q2[$];
  logic [W-1:0] q3[$];
  logic acc2;
  logic [W-1:0] nxt;
  always #5 clk = ~clk;
  pipe_stage_buf #(.WIDTH(W), .DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .flush(flush), .s_valid(s_valid), .s_ready(sr2), .s_data(s_data),
    .m_valid(mv2), .m_ready(m_ready), .m_data(md2), .count(cnt2));
  pipe_stage_buf #(.WIDTH(W), .DEPTH(3)) u_d3 (
    .clk(clk), .rst(rst), .flush(flush), .s_valid(s_valid), .s_ready(sr3), .s_data(s_data),
    .m_valid(mv3), .m_ready(m_ready), .m_data(md3), .count(cnt3));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic check_dut(input string tag, input int n, input int dep, input logic [31:0] head,
                           input logic sr, input logic mv, input logic [31:0] md, input logic [1:0] cnt);
    logic byp, emv;
    byp = BYP && n == 0 && s_valid && !flush;
    emv = byp || (n != 0 && !flush);
    chk({tag, ".count"}, 32'(cnt), 32'(n));
    chk({tag, ".s_ready"}, 32'(sr), 32'(n != dep));
    chk({tag, ".m_valid"}, 32'(mv), 32'(emv));
    if (emv) chk({tag, ".m_data"}, md, byp ? s_data : head);
  endtask
  task automatic model(inout logic [W-1:0] q[$], input int n, input int dep, input logic sv,
                       input logic [31:0] sd, input logic mr, output logic acc);
    acc = 1'b0;
    if (BYP && n == 0 && sv && mr) acc = 1'b1;
    else begin
      if (n != 0 && mr) void'(q.pop_front());
      if (sv && n < dep) begin
        q.push_back(sd);
        acc = 1'b1;
      end
    end
  endtask
  task automatic step(input logic sv, input logic [31:0] sd, input logic mr, input logic fl);
    int n2, n3;
    logic a3;
    @(negedge clk);
    s_valid = sv; s_data = sd; m_ready = mr; flush = fl;
    #1;
    n2 = q2.size();
    n3 = q3.size();
    check_dut("d2", n2, 2, n2 != 0 ? q2[0] : 32'h0, sr2, mv2, md2, cnt2);
    check_dut("d3", n3, 3, n3 != 0 ? q3[0] : 32'h0, sr3, mv3, md3, cnt3);
    @(posedge clk);
    acc2 = 1'b0;
    if (fl) begin
      q2.delete();
      q3.delete();
    end else begin
      model(q2, n2, 2, sv, sd, mr, acc2);
      model(q3, n3, 3, sv, sd, mr, a3);
    end
  endtask
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1; flush = 1'b1; s_valid = 1'b1; s_data = 32'hFFFF_FFFF; m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    q2.delete();
    q3.delete();
    #1;
    chk({tag, ".d2.count"}, 32'(cnt2), 0);
    chk({tag, ".d2.m_valid"}, 32'(mv2), 0);
    chk({tag, ".d2.s_ready"}, 32'(sr2), 1);
    chk({tag, ".d2.m_data"}, md2, 0);
    chk({tag, ".d3.count"}, 32'(cnt3), 0);
    chk({tag, ".d3.m_valid"}, 32'(mv3), 0);
    chk({tag, ".d3.m_data"}, md3, 0);
  endtask
  initial begin
    rst = 1'b1; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    do_reset("reset");
    step(1'b1, 32'hA, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0);
    step(1'b1, 32'hC, 1'b0, 1'b0);
    chk("full.d2.holds_c", 32'(acc2), 0);
    nxt = 32'hC;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, nxt, 1'b1, 1'b0);
      if (acc2) nxt = (nxt == 32'hC) ? 32'h100 : nxt + 1;
    end
    for (int i = 0; i < 3 && q2.size() < 2; i++) step(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
    chk("flush.d2.pre_full", 32'(q2.size()), 2);
    step(1'b1, 32'hD, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h55, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 80; i++)
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
    step(1'b1, 32'h77, 1'b0, 1'b0);
    step(1'b1, 32'h78, 1'b0, 1'b0);
    do_reset("midreset");
    step(1'b0, 32'h0, 1'b1, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
